// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage in-order pipeline.
// Handles memory back-pressure, multi-cycle MUL/DIV stalls, taken-branch squash
// and load-use interlock. Outputs are combinational; only state and count are registered.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_muldiv,
    input  logic       ex_is_div,
    input  logic       ex_branch_taken,
    input  logic       ma_mem_busy,
    output logic       pc_enable,
    output logic       if_id_enable,
    output logic       id_ex_enable,
    output logic       ex_ma_enable,
    output logic       ma_wb_enable,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_ma_flush,
    output logic       muldiv_start,
    output logic       muldiv_busy
);

    // Count must hold the largest latency minus one, whichever unit is slower.
    localparam int unsigned MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               load_use;

    // Load-use: EX holds a load whose non-x0 destination is read by ID.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // State and count register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and prioritised output decode: reset, memory busy, mul/div, branch, load-use.
    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        id_ex_enable = 1'b1;
        ex_ma_enable = 1'b1;
        ma_wb_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_ma_flush  = 1'b0;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        state_d      = state_q;
        count_d      = count_q;

        if (RESET) begin
            // Fill the pipeline with bubbles; keep garbage out of the register file.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_ma_flush  = 1'b1;
            ma_wb_enable = 1'b0;
        end else begin
            // The mul/div unit keeps running even while memory freezes the pipeline.
            if (state_q == BUSY) begin
                muldiv_busy = 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end

            if (ma_mem_busy) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_enable = 1'b0;
                ex_ma_enable = 1'b0;
                ma_wb_enable = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ex_muldiv) begin
                            muldiv_start = 1'b1;
                            muldiv_busy  = 1'b1;
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                            id_ex_enable = 1'b0;
                            ex_ma_flush  = 1'b1;
                            count_d      = ex_is_div ? CNT_W'(DIV_LATENCY - 1)
                                                     : CNT_W'(MUL_LATENCY - 1);
                            state_d      = BUSY;
                        end else if (ex_branch_taken) begin
                            // Squash both younger instructions; PC loads the target.
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (load_use) begin
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                            id_ex_flush  = 1'b1;
                        end
                    end
                    BUSY: begin
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                        id_ex_enable = 1'b0;
                        ex_ma_flush  = 1'b1;
                    end
                    DONE: begin
                        // Defaults let EX/MA capture the result; do not restart the same op.
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

endmodule
